// File: rtl/pcie_tx_arbiter.sv
// Two-source TLP arbiter in front of the PCIe core VC0 transmit port.
// Round-robin between completions (r0) and posted writes (r1), credit gated.
module pcie_tx_arbiter #(
  parameter int XFER_TMO = 1024
) (
  input  logic        sys_clk_125,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic [7:0]  r0_dcred,
  input  logic [7:0]  r1_dcred,
  output logic        r0_gnt,
  output logic        r1_gnt,
  input  logic        r0_st,
  input  logic        r0_end,
  input  logic        r0_nlfy,
  input  logic        r1_st,
  input  logic        r1_end,
  input  logic        r1_nlfy,
  input  logic [15:0] r0_data,
  input  logic [15:0] r1_data,
  input  logic [8:0]  tx_ca_ph_vc0,
  input  logic [8:0]  tx_ca_cplh_vc0,
  input  logic [12:0] tx_ca_pd_vc0,
  input  logic [12:0] tx_ca_cpld_vc0,
  output logic        tx_req_vc0,
  input  logic        tx_rdy_vc0,
  output logic        tx_st_vc0,
  output logic        tx_end_vc0,
  output logic        tx_nlfy_vc0,
  output logic [15:0] tx_data_vc0,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(XFER_TMO - 1);

  state_t      state;
  logic        sel;
  logic        rr;
  logic [15:0] cnt;

  logic        r0_hok;
  logic        r0_dok;
  logic        r1_hok;
  logic        r1_dok;
  logic        r0_ok;
  logic        r1_ok;
  logic        sel_ok;
  logic        in_xfer;
  logic        mux_st;
  logic        mux_end;
  logic        mux_nlfy;
  logic [15:0] mux_data;
  logic        tmo_hit;

  // Credit checks: bit 8 / bit 12 flag an infinite pool.
  assign r0_hok = tx_ca_cplh_vc0[8] |
                  (tx_ca_cplh_vc0[7:0] != 8'd0);
  assign r0_dok = tx_ca_cpld_vc0[12] |
                  (tx_ca_cpld_vc0[11:0] >= {4'd0, r0_dcred});
  assign r1_hok = tx_ca_ph_vc0[8] |
                  (tx_ca_ph_vc0[7:0] != 8'd0);
  assign r1_dok = tx_ca_pd_vc0[12] |
                  (tx_ca_pd_vc0[11:0] >= {4'd0, r1_dcred});

  assign r0_ok  = r0_req & r0_hok & r0_dok;
  assign r1_ok  = r1_req & r1_hok & r1_dok;
  assign sel_ok = sel ? r1_ok : r0_ok;

  assign in_xfer  = (state == XFER);
  assign mux_st   = sel ? r1_st   : r0_st;
  assign mux_end  = sel ? r1_end  : r0_end;
  assign mux_nlfy = sel ? r1_nlfy : r0_nlfy;
  assign mux_data = sel ? r1_data : r0_data;

  // Watchdog fires only if the requester has not ended the TLP itself.
  assign tmo_hit = in_xfer & (cnt == TMO_LAST) & ~mux_end;

  assign tx_st_vc0   = in_xfer & mux_st;
  assign tx_end_vc0  = (in_xfer & mux_end) | tmo_hit;
  assign tx_nlfy_vc0 = (in_xfer & mux_nlfy) | tmo_hit;
  assign tx_data_vc0 = in_xfer ? mux_data : 16'd0;
  assign tmo_err     = tmo_hit;

  // Arbitration FSM with registered request, grant and busy outputs.
  always_ff @(posedge sys_clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      rr         <= 1'b0;
      cnt        <= 16'd0;
      tx_req_vc0 <= 1'b0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r0_gnt <= 1'b0;
      r1_gnt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (r0_ok | r1_ok) begin
            sel        <= (r0_ok & r1_ok) ? rr : ~r0_ok;
            state      <= REQ;
            tx_req_vc0 <= 1'b1;
            busy       <= 1'b1;
          end
        end
        REQ: begin
          if (!sel_ok) begin
            state      <= IDLE;
            tx_req_vc0 <= 1'b0;
            busy       <= 1'b0;
          end else if (tx_rdy_vc0) begin
            state      <= XFER;
            tx_req_vc0 <= 1'b0;
            r0_gnt     <= ~sel;
            r1_gnt     <= sel;
            cnt        <= 16'd0;
          end
        end
        XFER: begin
          if (tmo_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            rr    <= ~rr;
          end else if (mux_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            rr    <= ~sel;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          tx_req_vc0 <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter.
// Expected grant order is queued as stimulus is set up and popped per grant.
module tb_pcie_tx_arbiter;

  logic        sys_clk_125 = 1'b0;
  logic        rst_n;
  logic        r0_req, r1_req;
  logic [7:0]  r0_dcred, r1_dcred;
  logic        r0_gnt, r1_gnt;
  logic        r0_st, r0_end, r0_nlfy;
  logic        r1_st, r1_end, r1_nlfy;
  logic [15:0] r0_data, r1_data;
  logic [8:0]  tx_ca_ph_vc0, tx_ca_cplh_vc0;
  logic [12:0] tx_ca_pd_vc0, tx_ca_cpld_vc0;
  logic        tx_req_vc0, tx_rdy_vc0;
  logic        tx_st_vc0, tx_end_vc0, tx_nlfy_vc0;
  logic [15:0] tx_data_vc0;
  logic        busy, tmo_err;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  pcie_tx_arbiter #(.XFER_TMO(16)) dut (
    .sys_clk_125    (sys_clk_125),
    .rst_n          (rst_n),
    .r0_req         (r0_req),
    .r1_req         (r1_req),
    .r0_dcred       (r0_dcred),
    .r1_dcred       (r1_dcred),
    .r0_gnt         (r0_gnt),
    .r1_gnt         (r1_gnt),
    .r0_st          (r0_st),
    .r0_end         (r0_end),
    .r0_nlfy        (r0_nlfy),
    .r1_st          (r1_st),
    .r1_end         (r1_end),
    .r1_nlfy        (r1_nlfy),
    .r0_data        (r0_data),
    .r1_data        (r1_data),
    .tx_ca_ph_vc0   (tx_ca_ph_vc0),
    .tx_ca_cplh_vc0 (tx_ca_cplh_vc0),
    .tx_ca_pd_vc0   (tx_ca_pd_vc0),
    .tx_ca_cpld_vc0 (tx_ca_cpld_vc0),
    .tx_req_vc0     (tx_req_vc0),
    .tx_rdy_vc0     (tx_rdy_vc0),
    .tx_st_vc0      (tx_st_vc0),
    .tx_end_vc0     (tx_end_vc0),
    .tx_nlfy_vc0    (tx_nlfy_vc0),
    .tx_data_vc0    (tx_data_vc0),
    .busy           (busy),
    .tmo_err        (tmo_err)
  );

  always #5 sys_clk_125 = ~sys_clk_125;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ne();
    @(negedge sys_clk_125);
    #1;
  endtask

  task automatic set_tlp(input int id, input logic st,
                         input logic en, input logic nl,
                         input logic [15:0] d);
    if (id == 0) begin
      r0_st = st; r0_end = en; r0_nlfy = nl; r0_data = d;
    end else begin
      r1_st = st; r1_end = en; r1_nlfy = nl; r1_data = d;
    end
  endtask

  task automatic wait_gnt();
    int got;
    int exp;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      ne();
      if (r0_gnt | r1_gnt) begin
        got = (r0_gnt & r1_gnt) ? 2 : (r1_gnt ? 1 : 0);
        break;
      end
    end
    exp = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
    chk("gnt_id", got, exp);
  endtask

  task automatic serve(input int id, input int n);
    logic [15:0] d;
    for (int b = 0; b < n; b++) begin
      @(negedge sys_clk_125);
      d = 16'hA000 + 16'(id * 256 + b);
      set_tlp(id, b == 0, b == n - 1, 1'b0, d);
      #1;
      if (b == 0) chk("gnt_pulse", id != 0 ? r1_gnt : r0_gnt, 0);
      chk("tx_st", tx_st_vc0, b == 0);
      chk("tx_end", tx_end_vc0, b == n - 1);
      chk("tx_nlfy", tx_nlfy_vc0, 0);
      chk("tx_data", tx_data_vc0, d);
    end
    @(negedge sys_clk_125);
    set_tlp(id, 1'b0, 1'b0, 1'b0, 16'd0);
    #1;
    chk("gap_busy", busy, 0);
    chk("gap_st", tx_st_vc0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_n = 1'b0;
    r0_req = 1'b1; r1_req = 1'b1;
    r0_dcred = 8'd0; r1_dcred = 8'd0;
    set_tlp(0, 1'b0, 1'b0, 1'b0, 16'd0);
    set_tlp(1, 1'b0, 1'b0, 1'b0, 16'd0);
    tx_ca_ph_vc0 = 9'h100; tx_ca_cplh_vc0 = 9'h100;
    tx_ca_pd_vc0 = 13'h1000; tx_ca_cpld_vc0 = 13'h1000;
    tx_rdy_vc0 = 1'b1;

    repeat (3) ne();
    chk("rst_req", tx_req_vc0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_frm", {tx_st_vc0, tx_end_vc0, tx_nlfy_vc0}, 0);
    chk("rst_data", tx_data_vc0, 0);

    // both requesting, infinite credits: alternate starting with r0
    @(negedge sys_clk_125);
    rst_n = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(1);
    ne();
    chk("req_rise", tx_req_vc0, 1);
    chk("busy_req", busy, 1);
    chk("no_early_gnt", {r0_gnt, r1_gnt}, 0);
    wait_gnt();
    chk("req_fall", tx_req_vc0, 0);
    serve(0, 2);
    wait_gnt();
    serve(1, 3);
    wait_gnt();
    serve(0, 1);
    wait_gnt();
    r0_req = 1'b0; r1_req = 1'b0;
    serve(1, 1);

    // r1 short of posted data credit
    tx_ca_pd_vc0 = 13'd4; r1_dcred = 8'd8;
    r0_req = 1'b1; r1_req = 1'b1;
    exp_q.push_back(0);
    wait_gnt();
    r0_req = 1'b0;
    serve(0, 1);
    g = 0;
    for (int i = 0; i < 6; i++) begin
      ne();
      if (r0_gnt | r1_gnt | busy) g++;
    end
    chk("r1_blocked", g, 0);
    tx_ca_pd_vc0 = 13'd8;
    exp_q.push_back(1);
    wait_gnt();
    r1_req = 1'b0;
    serve(1, 2);

    // r0 withdraws while in REQ
    tx_ca_pd_vc0 = 13'h1000; r1_dcred = 8'd0;
    tx_rdy_vc0 = 1'b0; r0_req = 1'b1;
    ne();
    chk("abort_req_up", tx_req_vc0, 1);
    r0_req = 1'b0; tx_rdy_vc0 = 1'b1;
    ne();
    chk("abort_req_fall", tx_req_vc0, 0);
    chk("abort_no_gnt", r0_gnt, 0);
    chk("abort_idle", busy, 0);
    ne();
    chk("abort_no_gnt2", {r0_gnt, r1_gnt}, 0);

    // r1 never ends: timeout on XFER cycle 16
    r1_req = 1'b1;
    exp_q.push_back(1);
    wait_gnt();
    r1_req = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      ne();
      if (k < 16) begin
        chk("tmo_early", {tx_end_vc0, tmo_err}, 0);
      end else begin
        chk("tmo_end", tx_end_vc0, 1);
        chk("tmo_nlfy", tx_nlfy_vc0, 1);
        chk("tmo_err", tmo_err, 1);
      end
    end
    ne();
    chk("tmo_pulse_off", tmo_err, 0);
    chk("tmo_idle", busy, 0);

    // rr toggled by timeout, then reset mid-XFER
    r0_req = 1'b1; r1_req = 1'b1;
    exp_q.push_back(1);
    wait_gnt();
    set_tlp(1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
    #1;
    chk("mid_xfer_data", tx_data_vc0, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    chk("arst_frm", {tx_st_vc0, tx_end_vc0, tx_nlfy_vc0}, 0);
    chk("arst_data", tx_data_vc0, 0);
    chk("arst_ctl", {tx_req_vc0, busy, r0_gnt, r1_gnt, tmo_err}, 0);
    set_tlp(1, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge sys_clk_125);
    rst_n = 1'b1;
    exp_q.push_back(0);
    wait_gnt();
    r0_req = 1'b0; r1_req = 1'b0;
    serve(0, 1);

    // r0 starved of completion header credit
    tx_ca_cplh_vc0 = 9'd0; tx_ca_ph_vc0 = 9'd1;
    r0_req = 1'b1; r1_req = 1'b1;
    repeat (3) exp_q.push_back(1);
    repeat (3) begin
      wait_gnt();
      serve(1, 1);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    ne();
    chk("final_idle", busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arbiter.md
PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 Parameter XFER_TMO, 1024, number of sys_clk_125 cycles allowed in XFER before forced termination (range 16..65535).
REQ-002 sys_clk_125  input  1  the only clock; all state is updated on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 r0_req / r1_req  input  1  each requests one TLP; r0 is the completion source and r1 is the posted-write source.
REQ-005 r0_dcred / r1_dcred  input  8  data credits the TLP needs (4-DW units); 0 means header-only.
REQ-006 r0_gnt / r1_gnt  output  1  one-cycle grant pulse; the requester drives its TLP starting next cycle.
REQ-007 r0_st, r0_end, r0_nlfy / r1_st, r1_end, r1_nlfy  input  1  per-requester TLP framing.
REQ-008 r0_data / r1_data  input  16  per-requester TLP data.
REQ-009 tx_ca_ph_vc0, tx_ca_cplh_vc0  input  9  core header credits; bit 8 set means infinite.
REQ-010 tx_ca_pd_vc0, tx_ca_cpld_vc0  input  13  core data credits; bit 12 set means infinite.
REQ-011 tx_req_vc0  output  1  request to the core's VC0 transmit port.
REQ-012 tx_rdy_vc0  input  1  core ready.
REQ-013 tx_st_vc0, tx_end_vc0, tx_nlfy_vc0  output  1  framing to the core.
REQ-014 tx_data_vc0  output  16  data to the core.
REQ-015 busy  output  1  high whenever the arbiter is not in IDLE.
REQ-016 tmo_err  output  1  one-cycle pulse when the XFER_TMO timeout fires.

Function
REQ-017 The state machine SHALL have states IDLE, REQ and XFER, plus a one-bit round-robin pointer rr that names the requester with priority.
REQ-018 A requester SHALL be eligible when its req is high, its header credit passes (infinite, or [7:0] >= 1) and its data credit passes (infinite, or [11:0] >= dcred zero-extended); r0 is checked against the cplh/cpld credits and r1 against the ph/pd credits.
REQ-019 In IDLE, if exactly one requester is eligible it SHALL be selected; if both are eligible, requester rr SHALL be selected; the next state is REQ.
REQ-020 A requester that is requesting but not eligible SHALL wait without blocking the other requester.
REQ-021 In REQ, tx_req_vc0 SHALL be high (registered, so it first rises one cycle after the IDLE decision).
REQ-022 In REQ, if the selected requester drops req, or its credit check fails before tx_rdy_vc0, tx_req_vc0 SHALL fall next cycle, the state SHALL return to IDLE and no grant SHALL be issued.
REQ-023 In REQ, on a cycle with tx_rdy_vc0 high, the arbiter SHALL drive tx_req_vc0 low next cycle, pulse the selected rN_gnt for exactly one cycle and enter XFER.
REQ-024 In XFER, tx_data/st/end/nlfy SHALL be a combinational mux of the granted requester's inputs; in every other state they SHALL be 0.
REQ-025 In XFER, on a cycle where tx_end_vc0 is high, the state SHALL go to IDLE next cycle and rr SHALL point to the other requester.
REQ-026 A 16-bit counter SHALL clear on entry to XFER and increment each XFER cycle.
REQ-027 When the counter reaches XFER_TMO-1 without an end, the arbiter SHALL force tx_end_vc0=1 and tx_nlfy_vc0=1 for that cycle, pulse tmo_err, toggle rr and return to IDLE.
REQ-028 There SHALL be at most one grant per IDLE-to-XFER pass; IDLE SHALL last at least one cycle between transfers.
REQ-029 busy SHALL be 1 in REQ and XFER and 0 in IDLE.

Reset
REQ-030 While rst_n is low, the arbiter SHALL asynchronously return to IDLE with rr=0, the counter at 0, and tx_req_vc0, gnts, tx_st/end/nlfy, tx_data_vc0, busy and tmo_err all at 0, including when reset hits mid-XFER.
REQ-031 After rst_n rises, the first arbitration SHALL occur on the first clock edge, with r0 preferred.

Verification
REQ-032 Both requests present, all credits infinite -> r0 granted first, then r1, alternating; tx_req_vc0 rises 1 cycle after the request, gnt pulse is 1 cycle wide.
REQ-033 r1_dcred=8 with pd=4 (finite) and r0 eligible -> only r0 served; pd raised to 8 -> r1 granted.
REQ-034 r0 drops req while in REQ before tx_rdy_vc0 -> tx_req_vc0 falls next cycle, no r0_gnt, return to IDLE.
REQ-035 Granted requester never asserts end, XFER_TMO=16 -> on XFER cycle 16, tx_end_vc0=tx_nlfy_vc0=tmo_err=1, then IDLE.
REQ-036 rst_n pulsed low mid-XFER -> all outputs 0 immediately; after release, rr=0 and r0 is preferred.
REQ-037 cplh=0 (finite), r0 requesting, r1 with ph=1 -> r1 granted repeatedly while r0 waits.
